// File: rtl/rr_mux_2x1_stage.sv
// Registered 2:1 selection stage with bounded-burst round-robin arbitration.
// A one-entry output register holds the selected word and the source it came from.
module rr_mux_2x1_stage #(
  parameter int WIDTH = 8,
  parameter int BURST = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i0,
  input  logic             v0,
  output logic             r0,
  input  logic [WIDTH-1:0] i1,
  input  logic             v1,
  output logic             r1,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             sel
);

  localparam logic [3:0] BURST_C = 4'(BURST);

  logic             cur_sel;
  logic [3:0]       cnt;
  logic             ld_en;
  logic             v_cur;
  logic             v_oth;
  logic             gnt;
  logic             gnt_vld;
  logic             acc;
  logic [WIDTH-1:0] mux_out;

  assign ld_en = !y_valid || y_ready;
  assign v_cur = cur_sel ? v1 : v0;
  assign v_oth = cur_sel ? v0 : v1;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    gnt     = cur_sel;
    gnt_vld = 1'b0;
    if (v_cur && (cnt < BURST_C)) begin
      gnt_vld = 1'b1;
    end else if (v_oth) begin
      gnt     = !cur_sel;
      gnt_vld = 1'b1;
    end else if (v_cur) begin
      gnt_vld = 1'b1;
    end
  end

  // Readies are forced low while reset is asserted so nothing is accepted then.
  assign acc     = !rst && ld_en && gnt_vld;
  assign r0      = acc && (gnt == 1'b0);
  assign r1      = acc && (gnt == 1'b1);
  assign mux_out = gnt ? i1 : i0;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= '0;
      y_valid <= 1'b0;
      sel     <= 1'b0;
      cur_sel <= 1'b0;
      cnt     <= 4'd0;
    end else if (acc) begin
      y       <= mux_out;
      sel     <= gnt;
      y_valid <= 1'b1;
      if ((gnt == cur_sel) && (cnt < BURST_C)) begin
        cnt <= cnt + 4'd1;
      end else begin
        // Switching source, or restarting after an uncontested exhausted burst.
        cur_sel <= gnt;
        cnt     <= 4'd1;
      end
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_2x1_stage.sv
// Directed self-checking bench for rr_mux_2x1_stage (WIDTH=8, BURST=2).
module tb_rr_mux_2x1_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i0, i1, y;
  logic       v0, v1, r0, r1, y_valid, y_ready, sel;

  int checks = 0;
  int errors = 0;
  int n0, n1;

  rr_mux_2x1_stage #(.WIDTH(8), .BURST(2)) dut (
    .clk(clk), .rst(rst),
    .i0(i0), .v0(v0), .r0(r0),
    .i1(i1), .v1(v1), .r1(r1),
    .y(y), .y_valid(y_valid), .y_ready(y_ready), .sel(sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_ready(input string tag, input logic er0, input logic er1);
    #1;
    check({tag, ".r0"}, 32'(r0), 32'(er0));
    check({tag, ".r1"}, 32'(r1), 32'(er1));
  endtask

  task automatic exp_out(input string tag, input logic [7:0] ey, input logic esel, input logic eyv);
    check({tag, ".y"}, 32'(y), 32'(ey));
    check({tag, ".sel"}, 32'(sel), 32'(esel));
    check({tag, ".y_valid"}, 32'(y_valid), 32'(eyv));
  endtask

  // Both sources valid, y_ready=1; expected grants follow 0,0,1,1,...
  task automatic run_fair(input int beats);
    logic src;
    logic [7:0] ey;
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < beats; k++) begin
      src = ((k / 2) % 2) == 1;
      i0 = 8'hA0 + 8'(n0);
      i1 = 8'hB0 + 8'(n1);
      v0 = 1'b1;
      v1 = 1'b1;
      y_ready = 1'b1;
      ey = src ? i1 : i0;
      exp_ready($sformatf("fair%0d", k), !src, src);
      tick();
      exp_out($sformatf("fair%0d", k), ey, src, 1'b1);
      if (src) n1++; else n0++;
    end
  endtask

  initial begin
    rst = 1'b1; v0 = 0; v1 = 0; i0 = 0; i1 = 0; y_ready = 1'b1;
    tick();
    tick();
    exp_out("reset", 8'h00, 1'b0, 1'b0);
    exp_ready("reset", 1'b0, 1'b0);

    // Fair sharing: A0,A1,B0,B1,A2,A3,B2,B3
    rst = 1'b0;
    run_fair(8);

    // Single source 1: six back-to-back beats
    v0 = 1'b0;
    v1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      i1 = 8'h10 + 8'(k);
      exp_ready($sformatf("single%0d", k), 1'b0, 1'b1);
      tick();
      exp_out($sformatf("single%0d", k), 8'h10 + 8'(k), 1'b1, 1'b1);
    end

    // Idle drain: y_valid drops, y and sel hold
    v1 = 1'b0;
    exp_ready("idle", 1'b0, 1'b0);
    tick();
    exp_out("idle", 8'h15, 1'b1, 1'b0);
    tick();
    exp_out("idle2", 8'h15, 1'b1, 1'b0);

    // Burst exhaustion: source 0 alone for two beats, then late competitor
    v0 = 1'b1; i0 = 8'h20;
    exp_ready("bx0", 1'b1, 1'b0);
    tick();
    exp_out("bx0", 8'h20, 1'b0, 1'b1);
    i0 = 8'h21;
    exp_ready("bx1", 1'b1, 1'b0);
    tick();
    exp_out("bx1", 8'h21, 1'b0, 1'b1);
    i0 = 8'h22; v1 = 1'b1; i1 = 8'h30;
    exp_ready("bx2", 1'b0, 1'b1);
    tick();
    exp_out("bx2", 8'h30, 1'b1, 1'b1);
    v1 = 1'b0;
    exp_ready("bx3", 1'b1, 1'b0);
    tick();
    exp_out("bx3", 8'h22, 1'b0, 1'b1);
    // cnt restarted at 1, so source 0 keeps one more beat against a competitor
    i0 = 8'h23; v1 = 1'b1; i1 = 8'h31;
    exp_ready("bx4", 1'b1, 1'b0);
    tick();
    exp_out("bx4", 8'h23, 1'b0, 1'b1);
    exp_ready("bx5", 1'b0, 1'b1);
    tick();
    exp_out("bx5", 8'h31, 1'b1, 1'b1);

    // Reset mid-operation while y holds B1
    rst = 1'b1; v0 = 0; v1 = 0;
    tick();
    rst = 1'b0;
    run_fair(4);
    exp_out("pre_rst", 8'hB1, 1'b1, 1'b1);
    rst = 1'b1;
    exp_ready("in_rst", 1'b0, 1'b0);
    tick();
    exp_out("post_rst", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    i0 = 8'hA0; i1 = 8'hB0;
    exp_ready("first_gnt", 1'b1, 1'b0);
    tick();
    exp_out("first_gnt", 8'hA0, 1'b0, 1'b1);

    // Backpressure for three cycles with both sources valid
    y_ready = 1'b0;
    i0 = 8'hA1;
    for (int k = 0; k < 3; k++) begin
      exp_ready($sformatf("bp%0d", k), 1'b0, 1'b0);
      tick();
      exp_out($sformatf("bp%0d", k), 8'hA0, 1'b0, 1'b1);
    end
    y_ready = 1'b1;
    exp_ready("bp_rel", 1'b1, 1'b0);
    tick();
    exp_out("bp_rel", 8'hA1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_mux_2x1_stage.md
Name: rr_mux_2x1_stage

Overview:
Registered, round-robin-arbitrated 2:1 selection stage built around our 2x1 mux datapath. It sits directly upstream of a downstream consumer. Each cycle it decides which of two valid/ready input streams drives the mux select, then captures the selected word into a one-entry output register. Fairness is bounded-burst round-robin, and the select used for each output word is exported alongside it.

Parameters:
WIDTH, 8, data width of i0, i1 and y.
BURST, 2, maximum consecutive accepted beats from one source while the other source is requesting (legal range 1..15).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
i0  input  WIDTH  source 0 data
v0  input  1  source 0 valid
r0  output  1  source 0 ready
i1  input  WIDTH  source 1 data
v1  input  1  source 1 valid
r1  output  1  source 1 ready
y  output  WIDTH  registered selected data
y_valid  output  1  y holds a word
y_ready  input  1  downstream accepts y
sel  output  1  source index of the word in y (registered)

Behaviour:
- Reset: sampled at the clk edge, overrides everything. After reset: y=0, y_valid=0, sel=0, internal cur_sel=0, cnt=0. Reset mid-transfer drops the held word with no flush.
- Load enable: ld_en = !y_valid || y_ready. Combinational.
- Grant (combinational from v0, v1, cur_sel, cnt):
  - keep = v[cur_sel] && cnt < BURST → grant = cur_sel.
  - else if v[!cur_sel] → grant = !cur_sel.
  - else if v[cur_sel] → grant = cur_sel (burst exhausted, no competitor).
  - else → no grant.
- Ready outputs:
  - r0 = ld_en && grant valid && grant==0; r1 likewise for source 1.
  - At most one ready is high at a time.
  - Ready may depend on v*. Sources must not make v* depend on r*.
- Accept on source s (v_s && r_s at the clk edge):
  - y <= i_s, sel <= s, y_valid <= 1.
  - If s==cur_sel and cnt<BURST: cnt <= cnt+1.
  - Otherwise: cur_sel <= s, cnt <= 1.
- No accept while ld_en: if y_ready, then y_valid <= 0. y and sel hold their last values.
- y_valid && !y_ready: y, sel, y_valid and the arbitration state all hold. r0=r1=0.
- Latency: exactly 1 cycle from input accept to y_valid.
- Throughput: 1 word/cycle. Simultaneous drain and load in the same cycle is required (no bubble).
- Counter: cnt is 4 bits wide and never exceeds BURST.
- Fairness: with both sources continuously valid and y_ready=1, the grant pattern is BURST beats from 0, then BURST from 1, repeating, starting with source 0 after reset.
- Ordering: no reordering within a source. Data is never duplicated or dropped except by reset.

Test Plan (WIDTH=8, BURST=2):
1. Fair sharing: release rst; hold v0=v1=1 with i0=8'hA0+n and i1=8'hB0+n, where n increments per accepted beat of each source; y_ready=1. Required: y sequence A0,A1,B0,B1,A2,A3,B2,B3; sel=0,0,1,1,0,0,1,1; y_valid high every cycle starting 1 cycle after the first accept.
2. Single source: v1=1, v0=0, y_ready=1, six beats 8'h10..8'h15. Required: all accepted back-to-back, sel=1 throughout, r0=0 throughout, y=10..15 in order.
3. Backpressure: after y=8'hA0 is loaded, hold y_ready=0 for 3 cycles with both sources valid. Required: y=A0, sel=0 and y_valid=1 stable; r0=r1=0. On y_ready=1, the next word A1 appears the following cycle.
4. Burst exhaustion with late competitor: v0=1 only for 2 beats, then raise v1. Required: the third grant goes to source 1. Then drop v1: source 0 is granted again with cnt restarting at 1.
5. Reset mid-operation: assert rst for 1 cycle while y_valid=1 and y=8'hB1. Required: the next cycle shows y=0, y_valid=0, sel=0, r0=r1=0 during rst. The first post-reset grant with both valid goes to source 0.
6. Idle/drain: both v=0, y_ready=1 with one word held. Required: y_valid drops after 1 cycle; y and sel retain their last values; no ready asserted.
